// File: rtl/seg7_scan_controller_if.sv
// seg7_scan_controller_if: valid/ready load channel carrying a 16-bit hex value to the scan controller
interface seg7_scan_controller_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  modport master (output load_valid, load_data, input load_ready);
  modport slave (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: frame-synchronous 4-digit seven-segment scanner with blanking gaps and leading-zero suppression
module seg7_scan_controller #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                    clk,
  input  logic                    RST_N,
  seg7_scan_controller_if.slave   load,
  input  logic                    lz_en,
  output logic [3:0]              Cathode,
  output logic [6:0]              Segment_out,
  output logic                    frame_done
);
  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MAXT) + 1;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic {BLANK, SHOW} state_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          full_q, full_d;
  logic [3:0]    cathode_q, cathode_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic          last, frame_end, accept, lz_blank, lit;
  logic [3:0]    nibble;
  // Next-state scan/handshake logic; outputs are precomputed from the next state so they are registered yet cycle-aligned
  always_comb begin
    last = (state_q == BLANK) ? (cnt_q == CW'(BLANK_TICKS - 1)) : (cnt_q == CW'(DIGIT_TICKS - 1));
    frame_end = (state_q == SHOW) && (idx_q == 2'd3) && last;
    accept = load.load_valid && !full_q;
    state_d = last ? ((state_q == BLANK) ? SHOW : BLANK) : state_q;
    idx_d = (last && state_q == SHOW) ? idx_q + 2'd1 : idx_q;
    cnt_d = last ? '0 : cnt_q + CW'(1);
    full_d = accept || (full_q && !frame_end);
    pending_d = accept ? load.load_data : pending_q;
    active_d = (frame_end && full_q) ? pending_q : active_q;
    nibble = active_d[{idx_d, 2'b00} +: 4];
    lz_blank = lz_en && ((idx_d == 2'd1 && active_d[15:4] == 12'h000) ||
                         (idx_d == 2'd2 && active_d[15:8] == 8'h00) ||
                         (idx_d == 2'd3 && active_d[15:12] == 4'h0));
    lit = (state_d == SHOW) && !lz_blank;
    cathode_d = lit ? ~(4'b0001 << idx_d) : 4'b1111;
    seg_d = lit ? HEX[nibble] : 7'h00;
    frame_done_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == CW'(DIGIT_TICKS - 1));
  end
  // State, data and output registers with asynchronous clear to the blank display
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      full_q       <= 1'b0;
      cathode_q    <= 4'b1111;
      seg_q        <= 7'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      full_q       <= full_d;
      cathode_q    <= cathode_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign load.load_ready = !full_q;
  assign Cathode = cathode_q;
  assign Segment_out = seg_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed table-driven checks of scan timing, load handshake, blanking and reset
module tb_seg7_scan_controller;
  typedef struct {
    int          cyc;
    logic        v;
    logic [15:0] d;
    logic        hold;
    logic        lz;
    logic [3:0]  cath;
    logic [6:0]  seg;
    logic        rdy;
    logic        fd;
  } vec_t;
  logic clk, RST_N, lz_en;
  logic [3:0] Cathode;
  logic [6:0] Segment_out;
  logic frame_done;
  int checks = 0, errors = 0, cyc = 0;
  logic hold = 1'b0;
  vec_t tbl[$];
  seg7_scan_controller_if lif();
  seg7_scan_controller #(.DIGIT_TICKS(3), .BLANK_TICKS(2)) dut (
    .clk(clk), .RST_N(RST_N), .load(lif), .lz_en(lz_en),
    .Cathode(Cathode), .Segment_out(Segment_out), .frame_done(frame_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
      if (!hold) lif.load_valid = 1'b0;
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] c, input logic [6:0] s, input logic r, input logic f);
    chk({tag, " cathode"}, 32'(Cathode), 32'(c));
    chk({tag, " segment"}, 32'(Segment_out), 32'(s));
    chk({tag, " ready"}, 32'(lif.load_ready), 32'(r));
    chk({tag, " frame_done"}, 32'(frame_done), 32'(f));
  endtask
  initial begin
    logic bad;
    //                cyc v  data     hold lz cath    seg    rdy fd
    tbl.push_back('{  0, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{  2, 0, 16'h0000, 0, 0, 4'hE, 7'h3F, 1, 0});
    tbl.push_back('{  4, 1, 16'h12AF, 0, 0, 4'hE, 7'h3F, 1, 0});
    tbl.push_back('{  5, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{  8, 0, 16'h0000, 0, 0, 4'hD, 7'h3F, 0, 0});
    tbl.push_back('{ 13, 0, 16'h0000, 0, 0, 4'hB, 7'h3F, 0, 0});
    tbl.push_back('{ 18, 0, 16'h0000, 0, 0, 4'h7, 7'h3F, 0, 0});
    tbl.push_back('{ 19, 0, 16'h0000, 0, 0, 4'h7, 7'h3F, 0, 1});
    tbl.push_back('{ 20, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{ 22, 0, 16'h0000, 0, 0, 4'hE, 7'h71, 1, 0});
    tbl.push_back('{ 27, 0, 16'h0000, 0, 0, 4'hD, 7'h77, 1, 0});
    tbl.push_back('{ 32, 0, 16'h0000, 0, 0, 4'hB, 7'h5B, 1, 0});
    tbl.push_back('{ 39, 0, 16'h0000, 0, 0, 4'h7, 7'h06, 1, 1});
    tbl.push_back('{ 40, 1, 16'h1111, 0, 0, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{ 41, 1, 16'h2222, 1, 0, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{ 50, 1, 16'h2222, 1, 0, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{ 59, 1, 16'h2222, 1, 0, 4'h7, 7'h06, 0, 1});
    tbl.push_back('{ 60, 1, 16'h2222, 0, 0, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{ 61, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{ 62, 0, 16'h0000, 0, 0, 4'hE, 7'h06, 0, 0});
    tbl.push_back('{ 79, 0, 16'h0000, 0, 0, 4'h7, 7'h06, 0, 1});
    tbl.push_back('{ 80, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{ 82, 1, 16'h0040, 0, 1, 4'hE, 7'h5B, 1, 0});
    tbl.push_back('{ 87, 0, 16'h0000, 0, 1, 4'hD, 7'h5B, 0, 0});
    tbl.push_back('{ 99, 0, 16'h0000, 0, 1, 4'h7, 7'h5B, 0, 1});
    tbl.push_back('{100, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{102, 1, 16'h0000, 0, 1, 4'hE, 7'h3F, 1, 0});
    tbl.push_back('{107, 0, 16'h0000, 0, 1, 4'hD, 7'h66, 0, 0});
    tbl.push_back('{112, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{117, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 0, 0});
    tbl.push_back('{119, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 0, 1});
    tbl.push_back('{122, 0, 16'h0000, 0, 1, 4'hE, 7'h3F, 1, 0});
    tbl.push_back('{127, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{132, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{137, 0, 16'h0000, 0, 1, 4'hF, 7'h00, 1, 0});
    tbl.push_back('{139, 0, 16'h0000, 0, 0, 4'hF, 7'h00, 1, 1});
    RST_N = 1'b0;
    lz_en = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk_all("reset", 4'hF, 7'h00, 1'b1, 1'b0);
    RST_N = 1'b1;
    cyc = 0;
    foreach (tbl[i]) begin
      goto(tbl[i].cyc);
      chk_all($sformatf("c%0d", cyc), tbl[i].cath, tbl[i].seg, tbl[i].rdy, tbl[i].fd);
      lif.load_valid = tbl[i].v;
      if (tbl[i].v) lif.load_data = tbl[i].d;
      hold = tbl[i].hold;
      lz_en = tbl[i].lz;
    end
    bad = 1'b0;
    for (int n = 140; n < 240; n++) begin
      goto(n);
      chk($sformatf("c%0d frame_done", n), 32'(frame_done), 32'((n % 20) == 19));
      if ((n % 20) == 19) chk($sformatf("c%0d pulse cathode", n), 32'(Cathode), 32'h7);
      if ($countones(~Cathode) > 1) bad = 1'b1;
    end
    chk("cathode one-hot", 32'(bad), 32'h0);
    goto(241);
    lif.load_valid = 1'b1;
    lif.load_data = 16'h5555;
    goto(252);
    chk_all("pre-reset c252", 4'hB, 7'h3F, 1'b0, 1'b0);
    RST_N = 1'b0;
    #1;
    chk_all("async reset", 4'hF, 7'h00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    cyc = 0;
    chk_all("rst2 c0", 4'hF, 7'h00, 1'b1, 1'b0);
    goto(2);
    chk_all("rst2 c2", 4'hE, 7'h3F, 1'b1, 1'b0);
    goto(19);
    chk_all("rst2 c19", 4'h7, 7'h3F, 1'b1, 1'b1);
    goto(22);
    chk_all("rst2 c22", 4'hE, 7'h3F, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for the 4-digit common-cathode seven-segment display. It owns the display resource. It accepts a 16-bit hex value over a valid/ready handshake and buffers it in a pending register. New values are committed only at frame boundaries, so a frame never mixes old and new data. The block then scans the digits with a programmable on-time and an all-off blanking gap between digits to suppress ghosting. It sits between the value-producing logic and the board pins, replacing free-running refresh logic in the display top.

## Interface
- DIGIT_TICKS, 50000: cycles each digit is driven; minimum 1.
- BLANK_TICKS, 500: cycles all digits are off before each digit; minimum 1.
- clk  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  16  hex value; nibble k drives digit k (digit 0 is rightmost).
- load_ready  out  1  pending register empty; a load is accepted when load_valid & load_ready.
- lz_en  in  1  leading-zero blanking enable.
- Cathode  out  4  digit select, active-low one-hot; Cathode[k]=0 drives digit k.
- Segment_out  out  7  segments, active-high, bit order {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- Reset, asynchronous, while RST_N=0:
  - outputs: Cathode=4'b1111, Segment_out=7'h00, load_ready=1, frame_done=0.
  - internal state: active=16'h0000, pending empty, state=BLANK, digit index=0, tick counter=0.
- The FSM has two states, BLANK and SHOW, plus a 2-bit digit index.
- BLANK: lasts BLANK_TICKS cycles with Cathode=4'b1111 and Segment_out=0, then enters SHOW with the same index.
- SHOW: lasts DIGIT_TICKS cycles, driving Cathode=~(4'b0001<<idx) and Segment_out=hex(active[4*idx+3:4*idx]). At the end:
  - idx wraps 3→0;
  - the FSM returns to BLANK.
- The tick counter resets to 0 on every state change. Its width is $clog2 of the larger parameter, plus 1.
- Hex encoding, values 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking:
  - applies when lz_en=1 at the cycle SHOW is driven;
  - a digit k in 1..3 is blanked if active[15:4k]==0;
  - a blanked digit drives Cathode=4'b1111 and Segment_out=0 for its SHOW period, keeping timing unchanged;
  - digit 0 is never blanked.
- Load handshake:
  - An accepted load writes pending and sets pending-full, so load_ready=0 from the next cycle.
  - Frame end is the last SHOW cycle of idx 3. At frame end, frame_done=1 for that cycle. If pending was full at the start of that cycle, active<=pending and pending clears, so load_ready=1 the next cycle.
  - If a load is accepted in the frame-end cycle while pending is empty, it goes to pending and commits at the next frame end.
- load_data is don't-care when load_valid=0. A valid load held while load_ready=0 is not accepted and must be held by the source.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Frame length is exactly 4*(BLANK_TICKS+DIGIT_TICKS) cycles. Cycle 0 is the first rising edge with RST_N=1.
- Cycles 0..BLANK_TICKS-1 are BLANK before digit 0. Cycles BLANK_TICKS..BLANK_TICKS+DIGIT_TICKS-1 show digit 0.
- Load-to-display latency: from acceptance to the start of the next frame, at most one frame plus one cycle.
- Reset mid-frame: outputs go to reset values immediately, without waiting for a clock edge. The pending value and active value are discarded. The scan restarts at BLANK idx 0.
- Cathode never has more than one bit low. There is never a cycle where both the outgoing and the incoming digit are driven.

## Test plan
All scenarios use BLANK_TICKS=2, DIGIT_TICKS=3, which gives a 20-cycle frame.
- Reset: hold RST_N=0 for 3 cycles → Cathode=1111, Segment_out=00, load_ready=1, frame_done=0; after release, first frame shows '0' (3F) on each digit.
- Load 16'h12AF at cycle 4 → load_ready=0 from cycle 5; frame_done at cycle 19; load_ready=1 at cycle 20; the second frame shows digit 0=71 (Cathode 1110), digit 1=77, digit 2=5B, digit 3=06.
- Backpressure: accept 16'h1111, then hold load_valid with 16'h2222 → not accepted until load_ready returns after frame end; 2222 is displayed one frame after 1111.
- Leading-zero blanking: lz_en=1 with value 0x0040 → digits 3 and 2 are blanked (1111/00), digit 1=66, digit 0=3F; value 0x0000 → only digit 0 is lit (3F).
- Reset mid-frame: drop RST_N during SHOW of idx 2 → outputs go to reset values before the next edge; after release, BLANK idx 0 and active=0 are restored.
- Frame pulse: over 5 frames, frame_done is high exactly once per 20 cycles, coincident with the last SHOW cycle of Cathode=0111.
